// File: rtl/column_window_assembler_pkg.sv
// Shared sizes and FSM encoding for the column window assembler.
// Imported by the top level and its testbench-facing defaults.
package column_window_assembler_pkg;

  localparam int CWA_K         = 3;
  localparam int CWA_PW        = 8;
  localparam int CWA_IMG_WIDTH = 8;
  localparam int CWA_OUT_ROWS  = 2;
  localparam int CWA_WIN_SUM_W =
    CWA_PW + $clog2(CWA_K * CWA_K);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cwa_state_t;

endpackage

// File: rtl/col_sum_tree.sv
// Combinational adder of N unsigned IN_W-bit values.
// Used for per-column sums and for the final window sum.
module col_sum_tree #(
  parameter int N     = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic [N*IN_W-1:0] i_data,
  output logic [OUT_W-1:0]  o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < N; i++) begin
      o_sum = o_sum + OUT_W'(i_data[i*IN_W +: IN_W]);
    end
  end

endmodule

// File: rtl/column_window_assembler.sv
// Builds K x K windows from a column stream and emits
// each window with its box sum, row and column index.
module column_window_assembler
  import column_window_assembler_pkg::*;
#(
  parameter int K           = CWA_K,
  parameter int PIXEL_WIDTH = CWA_PW,
  parameter int IMG_WIDTH   = CWA_IMG_WIDTH,
  parameter int OUT_ROWS    = CWA_OUT_ROWS,
  localparam int SUM_W  = PIXEL_WIDTH + $clog2(K * K),
  localparam int CW     = $clog2(IMG_WIDTH),
  localparam int RW     =
    (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
  localparam int COL_W  = K * PIXEL_WIDTH,
  localparam int WIN_W  = K * COL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             col_valid,
  input  logic [COL_W-1:0] col_data,
  input  logic             src_complete,
  output logic             win_valid,
  output logic [WIN_W-1:0] win_data,
  output logic [SUM_W-1:0] win_sum,
  output logic [RW-1:0]    win_row,
  output logic [CW-1:0]    win_col,
  output logic             busy,
  output logic             done,
  output logic             short_frame
);

  localparam int CSUM_W = PIXEL_WIDTH + $clog2(K);

  cwa_state_t r_state;
  cwa_state_t w_state_nxt;

  logic [CW-1:0]       r_cc;
  logic [RW-1:0]       r_rc;
  logic [WIN_W-1:0]    r_cols;
  logic                r_s1_valid;
  logic [WIN_W-1:0]    r_s1_win;
  logic [K*CSUM_W-1:0] r_s1_csum;
  logic [RW-1:0]       r_s1_row;
  logic [CW-1:0]       r_s1_col;

  logic                w_accept;
  logic                w_last;
  logic                w_win;
  logic                w_pipe_busy;
  logic [WIN_W-1:0]    w_next_cols;
  logic [K*CSUM_W-1:0] w_csum;
  logic [SUM_W-1:0]    w_win_sum;

  assign w_accept = (r_state == RUN) && col_valid;
  assign w_last   = w_accept
                 && (r_rc == RW'(OUT_ROWS - 1))
                 && (r_cc == CW'(IMG_WIDTH - 1));
  assign w_win    = w_accept && (r_cc >= CW'(K - 1));
  assign w_pipe_busy = r_s1_valid | win_valid;

  // Newest column enters at the top; slice 0 is the oldest.
  assign w_next_cols = {col_data, r_cols[WIN_W-1:COL_W]};

  for (genvar j = 0; j < K; j++) begin : g_col
    col_sum_tree #(
      .N     (K),
      .IN_W  (PIXEL_WIDTH),
      .OUT_W (CSUM_W)
    ) u_col_sum (
      .i_data (w_next_cols[j*COL_W +: COL_W]),
      .o_sum  (w_csum[j*CSUM_W +: CSUM_W])
    );
  end

  col_sum_tree #(
    .N     (K),
    .IN_W  (CSUM_W),
    .OUT_W (SUM_W)
  ) u_win_sum (
    .i_data (r_s1_csum),
    .o_sum  (w_win_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        if (w_last || src_complete)
          w_state_nxt = DONE;
      end
      DONE: if (!w_pipe_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // DONE waits for the pipeline to drain before pulsing.
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE) && !w_pipe_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cc        <= '0;
      r_rc        <= '0;
      short_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) begin
        r_cc        <= '0;
        r_rc        <= '0;
        short_frame <= 1'b0;
      end else if (w_accept) begin
        if (r_cc == CW'(IMG_WIDTH - 1)) begin
          r_cc <= '0;
          r_rc <= r_rc + 1'b1;
        end else begin
          r_cc <= r_cc + 1'b1;
        end
      end
      if (r_state == RUN && src_complete && !w_last)
        short_frame <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cols     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_win   <= '0;
      r_s1_csum  <= '0;
      r_s1_row   <= '0;
      r_s1_col   <= '0;
    end else begin
      r_s1_valid <= w_win;
      if (w_accept) r_cols <= w_next_cols;
      if (w_win) begin
        r_s1_win  <= w_next_cols;
        r_s1_csum <= w_csum;
        r_s1_row  <= r_rc;
        r_s1_col  <= r_cc - CW'(K - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_sum   <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= r_s1_valid;
      if (r_s1_valid) begin
        win_data <= r_s1_win;
        win_sum  <= w_win_sum;
        win_row  <= r_s1_row;
        win_col  <= r_s1_col;
      end
    end
  end

endmodule
